// File: rtl/uart_tx_parity.sv
// UART transmitter: start bit, LSB-first data, optional parity bit, stop bit.
// A frame is accepted from tx_start/tx_data only while idle.
module uart_tx_parity #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  // state  | meaning
  // IDLE   | line high, waiting for tx_start
  // START  | driving the start bit (0)
  // DATA   | driving data bit bit_idx, LSB first
  // PARITY | driving the parity bit (only when PARITY_EN=1)
  // STOP   | driving the stop bit (1)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          ODD_SEL   = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  logic [2:0]            state_q,  state_d;
  logic [CW-1:0]         baud_q,   baud_d;
  logic [BW-1:0]         bit_q,    bit_d;
  logic [DATA_WIDTH-1:0] shift_q,  shift_d;
  logic                  parity_q, parity_d;
  logic                  serial_q, serial_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic                  baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // tx_serial_d is derived from the next state so the line changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_start) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ODD_SEL;
          state_d  = START;
          baud_d   = '0;
          bit_d    = '0;
          serial_d = 1'b0;
          busy_d   = 1'b1;
        end
      end

      START: begin
        if (baud_last) begin
          baud_d   = '0;
          bit_d    = '0;
          state_d  = DATA;
          serial_d = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PAR_ON) begin
              state_d  = PARITY;
              serial_d = parity_q;
            end else begin
              state_d  = STOP;
              serial_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + BW'(1);
            shift_d  = shift_q >> 1;
            serial_d = shift_d[0];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      PARITY: begin
        if (baud_last) begin
          baud_d   = '0;
          state_d  = STOP;
          serial_d = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      STOP: begin
        if (baud_last) begin
          baud_d   = '0;
          state_d  = IDLE;
          serial_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end

      default: begin
        state_d  = IDLE;
        baud_d   = '0;
        bit_d    = '0;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_parity.sv
// Directed bench for uart_tx_parity: even, odd and no-parity instances at 4 clocks per bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_parity;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [1:0] sel;
  logic       go;

  logic start_e, start_o, start_n;
  logic ser_e, busy_e, done_e;
  logic ser_o, busy_o, done_o;
  logic ser_n, busy_n, done_n;
  logic obs_ser, obs_busy, obs_done;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start_e = go && (sel == 2'd0);
  assign start_o = go && (sel == 2'd1);
  assign start_n = go && (sel == 2'd2);

  assign obs_ser  = (sel == 2'd0) ? ser_e  : (sel == 2'd1) ? ser_o  : ser_n;
  assign obs_busy = (sel == 2'd0) ? busy_e : (sel == 2'd1) ? busy_o : busy_n;
  assign obs_done = (sel == 2'd0) ? done_e : (sel == 2'd1) ? done_o : done_n;

  uart_tx_parity #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .tx_start(start_e), .tx_data(tx_data),
    .tx_serial(ser_e), .tx_busy(busy_e), .tx_done(done_e));

  uart_tx_parity #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .tx_start(start_o), .tx_data(tx_data),
    .tx_serial(ser_o), .tx_busy(busy_o), .tx_done(done_o));

  uart_tx_parity #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .tx_start(start_n), .tx_data(tx_data),
    .tx_serial(ser_n), .tx_busy(busy_n), .tx_done(done_n));

  task automatic test_reset;
    rst_n   = 1'b0;
    go      = 1'b0;
    tx_data = 8'h00;
    sel     = 2'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      n_checks++;
      if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: ser=%b busy=%b done=%b, want ser=1 busy=0 done=0",
                 s, obs_ser, obs_busy, obs_done);
      end
    end
    sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Frame bit k of exp[] is the k-th bit on the line; 11 bits = start, 8 data, parity, stop.
  task automatic test_even_parity;
    logic [7:0]  dat [2];
    logic [10:0] exp [2];
    dat[0] = 8'h8F; exp[0] = 11'b11100011110;
    dat[1] = 8'h00; exp[1] = 11'b10000000000;
    sel = 2'd0;
    for (int v = 0; v < 2; v++) begin
      tx_data = dat[v];
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int k = 0; k < 44; k++) begin
        n_checks++;
        if (obs_ser !== exp[v][k/4] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
          n_fail++;
          $display("FAIL even_frame data=%h cyc=%0d: ser=%b busy=%b done=%b, want ser=%b busy=1 done=0",
                   dat[v], k, obs_ser, obs_busy, obs_done, exp[v][k/4]);
        end
        @(negedge clk);
      end
      n_checks++;
      if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b1) begin
        n_fail++;
        $display("FAIL even_end data=%h: ser=%b busy=%b done=%b, want ser=1 busy=0 done=1",
                 dat[v], obs_ser, obs_busy, obs_done);
      end
      @(negedge clk);
      n_checks++;
      if (obs_done !== 1'b0 || obs_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL even_done_width data=%h: done=%b busy=%b, want done=0 busy=0",
                 dat[v], obs_done, obs_busy);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_odd_parity;
    logic [7:0]  dat [2];
    logic [10:0] exp [2];
    dat[0] = 8'h8F; exp[0] = 11'b10100011110;
    dat[1] = 8'hFF; exp[1] = 11'b11111111110;
    sel = 2'd1;
    for (int v = 0; v < 2; v++) begin
      tx_data = dat[v];
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int k = 0; k < 44; k++) begin
        n_checks++;
        if (obs_ser !== exp[v][k/4] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
          n_fail++;
          $display("FAIL odd_frame data=%h cyc=%0d: ser=%b busy=%b done=%b, want ser=%b busy=1 done=0",
                   dat[v], k, obs_ser, obs_busy, obs_done, exp[v][k/4]);
        end
        @(negedge clk);
      end
      n_checks++;
      if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b1) begin
        n_fail++;
        $display("FAIL odd_end data=%h: ser=%b busy=%b done=%b, want ser=1 busy=0 done=1",
                 dat[v], obs_ser, obs_busy, obs_done);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_no_parity;
    logic [9:0] exp;
    exp = 10'b1101001010;
    sel = 2'd2;
    tx_data = 8'hA5;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 40; k++) begin
      n_checks++;
      if (obs_ser !== exp[k/4] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
        n_fail++;
        $display("FAIL nopar_frame cyc=%0d: ser=%b busy=%b done=%b, want ser=%b busy=1 done=0",
                 k, obs_ser, obs_busy, obs_done, exp[k/4]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b1) begin
      n_fail++;
      $display("FAIL nopar_end: ser=%b busy=%b done=%b, want ser=1 busy=0 done=1",
               obs_ser, obs_busy, obs_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ignore_busy_start;
    logic [10:0] exp;
    int busy_cnt;
    int done_cnt;
    exp = 11'b10100000010;
    sel = 2'd0;
    tx_data = 8'h81;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 44; k++) begin
      n_checks++;
      if (obs_ser !== exp[k/4] || obs_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_start_frame cyc=%0d: ser=%b busy=%b, want ser=%b busy=1",
                 k, obs_ser, obs_busy, exp[k/4]);
      end
      if (k == 10) begin
        tx_data = 8'h3C;
        go = 1'b1;
      end else if (k == 11) begin
        go = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if (obs_done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_start_done: done=%b, want 1", obs_done);
    end
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (obs_busy === 1'b1 || obs_ser !== 1'b1) busy_cnt++;
      if (obs_done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (busy_cnt !== 0 || done_cnt !== 0) begin
      n_fail++;
      $display("FAIL busy_start_no_second: busy/low cycles=%0d dones=%0d, want 0 and 0",
               busy_cnt, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] exp1;
    logic [10:0] exp2;
    exp1 = 11'b10010101010;
    exp2 = 11'b10101010100;
    sel = 2'd0;
    tx_data = 8'h55;
    go = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 44; k++) begin
      n_checks++;
      if (obs_ser !== exp1[k/4] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_frame1 cyc=%0d: ser=%b busy=%b done=%b, want ser=%b busy=1 done=0",
                 k, obs_ser, obs_busy, obs_done, exp1[k/4]);
      end
      if (k == 5) tx_data = 8'hAA;
      @(negedge clk);
    end
    n_checks++;
    if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: ser=%b busy=%b done=%b, want ser=1 busy=0 done=1",
               obs_ser, obs_busy, obs_done);
    end
    @(negedge clk);
    for (int k = 45; k < 89; k++) begin
      n_checks++;
      if (obs_ser !== exp2[(k-45)/4] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_frame2 cyc=%0d: ser=%b busy=%b done=%b, want ser=%b busy=1 done=0",
                 k, obs_ser, obs_busy, obs_done, exp2[(k-45)/4]);
      end
      if (k == 60) go = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done2: done=%b busy=%b, want done=1 busy=0", obs_done, obs_busy);
    end
    @(negedge clk);
    n_checks++;
    if (obs_busy !== 1'b0 || obs_done !== 1'b0 || obs_ser !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_no_third: ser=%b busy=%b done=%b, want ser=1 busy=0 done=0",
               obs_ser, obs_busy, obs_done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] exp_f0;
    logic [10:0] exp_3c;
    int bad_cnt;
    exp_f0 = 11'b10111100000;
    exp_3c = 11'b10001111000;
    sel = 2'd0;
    tx_data = 8'hF0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 18; k++) begin
      n_checks++;
      if (obs_ser !== exp_f0[k/4] || obs_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_pre cyc=%0d: ser=%b busy=%b, want ser=%b busy=1",
                 k, obs_ser, obs_busy, exp_f0[k/4]);
      end
      if (k < 17) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (obs_ser !== 1'b1 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: ser=%b busy=%b done=%b, want ser=1 busy=0 done=0",
               obs_ser, obs_busy, obs_done);
    end
    bad_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (obs_done !== 1'b0 || obs_busy !== 1'b0 || obs_ser !== 1'b1) bad_cnt++;
    end
    n_checks++;
    if (bad_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_quiet: non-idle cycles=%0d, want 0", bad_cnt);
    end
    tx_data = 8'h3C;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 44; k++) begin
      n_checks++;
      if (obs_ser !== exp_3c[k/4] || obs_busy !== 1'b1 || obs_done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_new cyc=%0d: ser=%b busy=%b done=%b, want ser=%b busy=1 done=0",
                 k, obs_ser, obs_busy, obs_done, exp_3c[k/4]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (obs_done !== 1'b1 || obs_busy !== 1'b0 || obs_ser !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_new_end: ser=%b busy=%b done=%b, want ser=1 busy=0 done=1",
               obs_ser, obs_busy, obs_done);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    go       = 1'b0;
    sel      = 2'd0;
    tx_data  = 8'h00;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity();
    test_ignore_busy_start();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
